// File: rtl/stream_gen_pkg.sv
// Shared types, constants and LFSR step function for the stream generator/checker.
package stream_gen_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Sender FSM: idle countdown between words, or presenting a word.
  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SEND = 1'b1
  } send_state_e;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [LFSR_W-1:0] lfsr_seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/stream_lfsr.sv
// Free-running 16-bit Galois LFSR shared by the sender gap draw and the
// checker back-pressure. Loads its seed on synchronous active-low reset.
module stream_lfsr
  import stream_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'h1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] lfsr_o
);

  localparam logic [LFSR_W-1:0] SEED_EFF = lfsr_seed_fix(SEED);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Next state: advance one step every cycle.
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  // State register with seed load on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= SEED_EFF;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/stream_gen_check.sv
// Traffic generator and in-order checker. The sender emits an incrementing
// sequence with pseudo-random idle gaps; the checker compares each accepted
// word against its expected value, resyncing after a mismatch. tx_* and rx_*
// share only the LFSR state, never a combinational path.
module stream_gen_check
  import stream_gen_pkg::*;
#(
  parameter int unsigned       WIDTH = 4,
  parameter int unsigned       GAP_W = 8,
  parameter int unsigned       CNT_W = 16,
  parameter logic [LFSR_W-1:0] SEED  = 16'h1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [GAP_W-1:0] gap_from,
  input  logic [GAP_W-1:0] gap_to,
  input  logic             rx_stall_en,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [WIDTH-1:0] expected,
  output logic             failure,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_unused;

  stream_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr_o(lfsr)
  );

  // Only the low GAP_W bits and the MSB are consumed.
  assign lfsr_unused = ^lfsr;

  // ---------------------------------------------------------------------------
  // Gap draw: used only on the cycle of a sender handshake.
  // ---------------------------------------------------------------------------
  logic [GAP_W:0]   gap_span;
  logic [GAP_W-1:0] gap_g;

  // Pick G in [gap_from, gap_to]; an empty or inverted range yields gap_from.
  always_comb begin
    gap_span = {1'b0, gap_to} - {1'b0, gap_from} + (GAP_W+1)'(1);
    if (gap_to <= gap_from) begin
      gap_g = gap_from;
    end else begin
      gap_g = gap_from + GAP_W'({1'b0, lfsr[GAP_W-1:0]} % gap_span);
    end
  end

  // ---------------------------------------------------------------------------
  // Sender
  // ---------------------------------------------------------------------------
  send_state_e      state_q, state_d;
  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Sender next state: count down the gap, then hold the word until taken.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    tx_valid = 1'b0;
    case (state_q)
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_SEND;
        else             cnt_d   = cnt_q - GAP_W'(1);
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          data_d = data_q + WIDTH'(1);
          if (gap_g != '0) begin
            state_d = ST_GAP;
            cnt_d   = gap_g - GAP_W'(1);
          end
        end
      end
      default: state_d = ST_GAP;
    endcase
  end

  // Sender registers; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_GAP;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign tx_data = data_q;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             rx_hs;

  // Back-pressure comes from registered LFSR state only.
  always_comb begin
    rx_ready = rx_stall_en ? lfsr[LFSR_W-1] : 1'b1;
  end

  // Checker next state: count words, compare, resync on mismatch.
  always_comb begin
    rx_hs   = rx_valid & rx_ready;
    exp_d   = exp_q;
    fail_d  = fail_q;
    err_d   = err_q;
    words_d = words_q;
    if (rx_hs) begin
      words_d = words_q + CNT_W'(1);
      if (rx_data == exp_q) begin
        exp_d = exp_q + WIDTH'(1);
      end else begin
        fail_d = 1'b1;
        exp_d  = rx_data + WIDTH'(1);
        if (err_q != '1) err_d = err_q + CNT_W'(1);
      end
    end
  end

  // Checker registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q   <= '0;
      fail_q  <= 1'b0;
      err_q   <= '0;
      words_q <= '0;
    end else begin
      exp_q   <= exp_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

  assign expected = exp_q;
  assign failure  = fail_q;
  assign err_cnt  = err_q;
  assign word_cnt = words_q;

endmodule
